// File: rtl/sign_extend.sv
// Immediate widening unit: sign-, zero- or upper-placement of a WIDTH-bit immediate,
// with a combinational result and a load-enabled registered copy.
module sign_extend #(
    parameter int WIDTH     = 8,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     imm,
    input  logic                 sign,
    input  logic                 upper,
    input  logic                 load,
    output logic [OUT_WIDTH-1:0] y,
    output logic [OUT_WIDTH-1:0] y_q,
    output logic                 neg
);

    logic [OUT_WIDTH-1:0] ext;

    generate
        if (WIDTH < 1 || WIDTH > OUT_WIDTH) begin : g_illegal
            $error("sign_extend: WIDTH=%0d must be in 1..OUT_WIDTH=%0d", WIDTH, OUT_WIDTH);
            assign ext = '0;
        end else if (WIDTH == OUT_WIDTH) begin : g_same
            // No fill bits exist, so every mode passes the immediate straight through.
            assign ext = imm;
        end else begin : g_fill
            localparam int FILL = OUT_WIDTH - WIDTH;
            always_comb begin
                ext = {{FILL{1'b0}}, imm};
                if (upper) begin
                    ext = {imm, {FILL{1'b0}}};
                end else if (sign) begin
                    ext = {{FILL{imm[WIDTH-1]}}, imm};
                end
            end
        end
    endgenerate

    assign y   = ext;
    assign neg = ext[OUT_WIDTH-1];

    // load is a plain enable (no handshake): y is captured on every rising clk with load=1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_q <= '0;
        end else if (load) begin
            y_q <= y;
        end
    end

endmodule

// File: tb/tb_sign_extend.sv
// Scoreboard bench for sign_extend: drivers push hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_sign_extend;

    logic        clk;
    logic        reset_n;
    logic [7:0]  imm;
    logic        sign;
    logic        upper;
    logic        load;
    logic [15:0] y;
    logic [15:0] y_q;
    logic        neg;

    // expectation scoreboard: kind 0 = y, 1 = neg, 2 = y_q
    logic [15:0] exp_q[$];
    int          kind_q[$];
    string       name_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] yq_model;

    sign_extend #(.WIDTH(8), .OUT_WIDTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .imm     (imm),
        .sign    (sign),
        .upper   (upper),
        .load    (load),
        .y       (y),
        .y_q     (y_q),
        .neg     (neg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input int kind, input logic [15:0] e, input string name);
        kind_q.push_back(kind);
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    // one cycle: drive just after posedge, expectations checked at the following negedge
    task automatic drive(input logic [7:0] i, input logic s, input logic u, input logic l,
                         input logic rst, input logic [15:0] exp_y, input logic exp_n,
                         input string name);
        @(posedge clk);
        #1;
        imm = i; sign = s; upper = u; load = l; reset_n = rst;
        push(0, exp_y, {name, ".y"});
        push(1, {15'd0, exp_n}, {name, ".neg"});
        push(2, rst ? yq_model : 16'h0000, {name, ".y_q"});
        if (!rst)      yq_model = 16'h0000;
        else if (l)    yq_model = exp_y;
    endtask

    // monitor
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            int          k;
            logic [15:0] e;
            logic [15:0] act;
            string       nm;
            k  = kind_q.pop_front();
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            act = (k == 0) ? y : (k == 1) ? {15'd0, neg} : y_q;
            n_checks++;
            if (act === e) n_pass++;
            else $display("FAIL %s: got %h expected %h", nm, act, e);
        end
    end

    initial begin
        reset_n = 1'b0; imm = 8'h00; sign = 1'b0; upper = 1'b0; load = 1'b0;
        yq_model = 16'h0000;
        #2;
        push(2, 16'h0000, "reset.y_q");
        @(negedge clk);
        #1;
        reset_n = 1'b1;

        //     imm    s     u     ld    rst   exp_y      neg
        drive(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00FF, 1'b0, "zext_ff");
        drive(8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1, "sext_ff");
        drive(8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 16'h007F, 1'b0, "sext_7f");
        drive(8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFF80, 1'b1, "sext_80");
        drive(8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0080, 1'b0, "zext_80");
        drive(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 16'hA500, 1'b1, "upper_s1");
        drive(8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 16'hA500, 1'b1, "upper_s0");
        // async reset mid-cycle (checked before the next rising edge), then held low
        drive(8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0012, 1'b0, "async_rst");
        drive(8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0033, 1'b0, "rst_held");
        // release and capture on the first edge with reset_n high and load=1
        drive(8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFF80, 1'b1, "load_80");
        drive(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, "hold_01");
        drive(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00FE, 1'b0, "hold_fe");
        drive(8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, "hold_01b");
        drive(8'hFE, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b1, "sext_fe");

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
